// File: rtl/usb_pkg.sv
// Shared USB peripheral definitions: device codes, register offsets, sequencer states, STA layout.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package usb_pkg;

  // Device codes as written to CCR[2:0]; 0 and 7 both park the port.
  typedef enum logic [2:0] {
    DEV_RESET    = 3'd0,
    DEV_AUDIO    = 3'd1,
    DEV_CAMERA   = 3'd2,
    DEV_DISK     = 3'd3,
    DEV_KEYBOARD = 3'd4,
    DEV_SERIAL   = 3'd5,
    DEV_SERIAL2  = 3'd6,
    DEV_RESET2   = 3'd7
  } dev_e;

  localparam int NUM_DEV = 6;

  // Register file byte offsets.
  localparam logic [3:0] REG_CCR = 4'd0;
  localparam logic [3:0] REG_RDR = 4'd4;
  localparam logic [3:0] REG_TDR = 4'd8;
  localparam logic [3:0] REG_STA = 4'd12;

  // Port sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DISC   = 3'd1,
    ST_RSTDEV = 3'd2,
    ST_ENUM   = 3'd3,
    ST_ACTIVE = 3'd4,
    ST_FAULT  = 3'd5
  } seq_state_e;

  // STA bit positions.
  localparam int STA_CONN_BIT    = 0;
  localparam int STA_BUSY_BIT    = 1;
  localparam int STA_TIMEOUT_BIT = 2;
  localparam int STA_DEV_LSB     = 4;
  localparam int STA_DEV_MSB     = 6;

  // Codes that park the port rather than attach a device core.
  function automatic logic is_park(input logic [2:0] code);
    return (code == DEV_RESET) || (code == DEV_RESET2);
  endfunction

  // One-hot per-device vector, bit k-1 for device k; park codes give all zeros.
  function automatic logic [NUM_DEV-1:0] dev_onehot(input logic [2:0] code);
    logic [NUM_DEV-1:0] oh;
    oh = '0;
    for (int k = 1; k <= NUM_DEV; k++) begin
      if (code == 3'(k)) oh[k-1] = 1'b1;
    end
    return oh;
  endfunction

  // STA word describing a sequencer state for the given target device.
  function automatic logic [31:0] sta_word(input seq_state_e st, input logic [2:0] tgt);
    logic [31:0] w;
    w = '0;
    w[STA_CONN_BIT]    = (st == ST_ACTIVE);
    w[STA_BUSY_BIT]    = (st inside {ST_DISC, ST_RSTDEV, ST_ENUM});
    w[STA_TIMEOUT_BIT] = (st == ST_FAULT);
    if (st inside {ST_ENUM, ST_ACTIVE, ST_FAULT}) w[STA_DEV_MSB:STA_DEV_LSB] = tgt;
    return w;
  endfunction

endpackage

// File: rtl/usb_dwell_timer.sv
// Loadable down-counter used to time how long the sequencer dwells in a state.
// Latency: load takes effect on the next edge; zero_o is a decode of the current count.
// Backpressure: none; counts every cycle and holds at zero.
module usb_dwell_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             zero_o
);

  // Load on request, otherwise count down and stick at zero.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      value_o <= '0;
    end else if (load_i) begin
      value_o <= load_val_i;
    end else if (value_o != '0) begin
      value_o <= value_o - CNT_W'(1);
    end
  end

  assign zero_o = (value_o == '0);

endmodule

// File: rtl/usb_port_sequencer.sv
// Hands the shared USB port between device cores: disconnect, core reset, connect-and-wait.
// Latency: request seen at edge n gives DISC from edge n+1; STA write one cycle after each state change.
// Backpressure: none; a new request restarts the sequence from any state.
module usb_port_sequencer
  import usb_pkg::*;
#(
  parameter int unsigned DISC_CYCLES  = 480000,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned CONN_TIMEOUT = 48000000,
  parameter int          CNT_W        = 26
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [2:0]   req_sel_i,
  input  logic [5:0]   dev_connected_i,
  output logic [2:0]   port_sel_o,
  output logic [5:0]   dev_rstn_o,
  output logic         busy_o,
  output logic         sta_we_o,
  output logic [31:0]  sta_data_o
);

  // The timer reloads N-1 so a state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] DISC_LD = CNT_W'(DISC_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONN_LD = CNT_W'(CONN_TIMEOUT - 1);

  seq_state_e       state, prev_state, nxt_state;
  logic [2:0]       tgt, nxt_tgt;
  logic             req_chg, tgt_conn;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_load_val, tmr_value;
  logic             tmr_value_unused;

  usb_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .value_o    (tmr_value),
    .zero_o     (tmr_zero)
  );

  // The raw count is exported by the timer for debug; only its zero decode steers the FSM.
  assign tmr_value_unused = ^tmr_value;

  assign req_chg  = (req_sel_i != tgt);
  assign tgt_conn = |(dev_connected_i & dev_onehot(tgt));
  assign nxt_tgt  = req_chg ? req_sel_i : tgt;

  // Next state and timer reload; a changed request overrides everything else.
  always_comb begin
    nxt_state    = state;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    if (req_chg) begin
      nxt_state    = ST_DISC;
      tmr_load     = 1'b1;
      tmr_load_val = DISC_LD;
    end else begin
      case (state)
        ST_DISC: begin
          if (tmr_zero) begin
            if (is_park(tgt)) begin
              nxt_state = ST_IDLE;
            end else begin
              nxt_state    = ST_RSTDEV;
              tmr_load     = 1'b1;
              tmr_load_val = RST_LD;
            end
          end
        end
        ST_RSTDEV: begin
          if (tmr_zero) begin
            nxt_state    = ST_ENUM;
            tmr_load     = 1'b1;
            tmr_load_val = CONN_LD;
          end
        end
        ST_ENUM: begin
          if (tgt_conn)      nxt_state = ST_ACTIVE;
          else if (tmr_zero) nxt_state = ST_FAULT;
        end
        ST_ACTIVE: begin
          if (!tgt_conn) begin
            nxt_state    = ST_ENUM;
            tmr_load     = 1'b1;
            tmr_load_val = CONN_LD;
          end
        end
        default: nxt_state = state;
      endcase
    end
  end

  // State, target and registered port controls; STA posts the state entered on the previous edge.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      prev_state <= ST_IDLE;
      tgt        <= 3'd0;
      port_sel_o <= 3'd0;
      dev_rstn_o <= 6'b0;
      busy_o     <= 1'b0;
      sta_we_o   <= 1'b0;
      sta_data_o <= 32'd0;
    end else begin
      state      <= nxt_state;
      prev_state <= state;
      tgt        <= nxt_tgt;
      if (nxt_state inside {ST_ENUM, ST_ACTIVE}) begin
        port_sel_o <= nxt_tgt;
        dev_rstn_o <= dev_onehot(nxt_tgt);
      end else begin
        port_sel_o <= 3'd0;
        dev_rstn_o <= 6'b0;
      end
      busy_o     <= (nxt_state inside {ST_DISC, ST_RSTDEV, ST_ENUM});
      sta_we_o   <= (state != prev_state);
      sta_data_o <= sta_word(state, tgt);
    end
  end

endmodule

// File: tb/tb_usb_port_sequencer.sv
// Directed bench for usb_port_sequencer with an STA scoreboard.
// Latency: expectations carry the exact cycle each STA write must appear.
// Backpressure: none.
module tb_usb_port_sequencer;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [2:0]  req_sel_i;
  logic [5:0]  dev_connected_i;
  logic [2:0]  port_sel_o;
  logic [5:0]  dev_rstn_o;
  logic        busy_o;
  logic        sta_we_o;
  logic [31:0] sta_data_o;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
  } sta_exp_t;

  sta_exp_t sb[$];
  sta_exp_t mon_e;
  int       cyc      = 0;
  int       n_checks = 0;
  int       n_fail   = 0;
  logic     watch3   = 1'b0;
  logic     saw3     = 1'b0;
  int       c0, t, m, a, d, u, r;

  usb_port_sequencer #(
    .DISC_CYCLES  (8),
    .RST_CYCLES   (4),
    .CONN_TIMEOUT (32),
    .CNT_W        (26)
  ) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .req_sel_i       (req_sel_i),
    .dev_connected_i (dev_connected_i),
    .port_sel_o      (port_sel_o),
    .dev_rstn_o      (dev_rstn_o),
    .busy_o          (busy_o),
    .sta_we_o        (sta_we_o),
    .sta_data_o      (sta_data_o)
  );

  // Clock and edge counter.
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after edge c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic exp_sta(input int c, input logic [31:0] v);
    sta_exp_t e;
    e.cyc = c;
    e.dat = v;
    sb.push_back(e);
  endtask

  // Monitor: every STA write must match the oldest expectation in value and cycle.
  always @(negedge clk_i) begin
    if (watch3 && dev_rstn_o[3]) saw3 = 1'b1;
    if (sta_we_o === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sta_unexpected: write %h at cycle %0d, none expected", sta_data_o, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || sta_data_o !== mon_e.dat) begin
          n_fail++;
          $display("FAIL sta_post: got %h at cycle %0d, expected %h at cycle %0d",
                   sta_data_o, cyc, mon_e.dat, mon_e.cyc);
        end
      end
    end
  end

  // Global time limit.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i          = 1'b0;
    req_sel_i       = 3'd0;
    dev_connected_i = 6'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_port_sel", 32'(port_sel_o), 32'd0);
    chk("rst_dev_rstn", 32'(dev_rstn_o), 32'd0);
    chk("rst_busy",     32'(busy_o),     32'd0);
    chk("rst_sta_we",   32'(sta_we_o),   32'd0);
    chk("rst_sta_data", sta_data_o,      32'd0);
    rstn_i = 1'b1;
    goto(cyc + 2);

    // Normal attach of device 1.
    c0 = cyc;
    req_sel_i = 3'd1;
    exp_sta(c0 + 2,  32'h02);
    exp_sta(c0 + 10, 32'h02);
    exp_sta(c0 + 14, 32'h12);
    exp_sta(c0 + 22, 32'h11);
    goto(c0 + 8);
    chk("attach_disc_busy", 32'(busy_o),     32'd1);
    chk("attach_disc_port", 32'(port_sel_o), 32'd0);
    chk("attach_disc_rstn", 32'(dev_rstn_o), 32'd0);
    goto(c0 + 12);
    chk("attach_rstdev_port", 32'(port_sel_o), 32'd0);
    goto(c0 + 13);
    chk("attach_enum_port", 32'(port_sel_o), 32'd1);
    chk("attach_enum_rstn", 32'(dev_rstn_o), 32'h01);
    chk("attach_enum_busy", 32'(busy_o),     32'd1);
    goto(c0 + 20);
    dev_connected_i = 6'b000001;
    chk("attach_wait_busy", 32'(busy_o), 32'd1);
    goto(c0 + 21);
    chk("attach_active_busy", 32'(busy_o),     32'd0);
    chk("attach_active_port", 32'(port_sel_o), 32'd1);

    // Timeout on device 3.
    t = c0 + 25;
    goto(t);
    req_sel_i       = 3'd3;
    dev_connected_i = 6'b0;
    exp_sta(t + 2,  32'h02);
    exp_sta(t + 10, 32'h02);
    exp_sta(t + 14, 32'h32);
    exp_sta(t + 46, 32'h34);
    goto(t + 13);
    chk("tmo_enum_port", 32'(port_sel_o), 32'd3);
    chk("tmo_enum_rstn", 32'(dev_rstn_o), 32'h04);
    goto(t + 44);
    chk("tmo_last_enum_busy", 32'(busy_o),     32'd1);
    chk("tmo_last_enum_port", 32'(port_sel_o), 32'd3);
    goto(t + 45);
    chk("tmo_fault_port", 32'(port_sel_o), 32'd0);
    chk("tmo_fault_busy", 32'(busy_o),     32'd0);
    chk("tmo_fault_rstn", 32'(dev_rstn_o), 32'd0);
    goto(t + 60);
    chk("tmo_hold_port", 32'(port_sel_o), 32'd0);
    chk("tmo_hold_busy", 32'(busy_o),     32'd0);

    // Request 4 replaced by 5 during RSTDEV.
    m = t + 62;
    goto(m);
    req_sel_i = 3'd4;
    watch3    = 1'b1;
    exp_sta(m + 2,  32'h02);
    exp_sta(m + 10, 32'h02);
    goto(m + 10);
    req_sel_i = 3'd5;
    exp_sta(m + 12, 32'h02);
    exp_sta(m + 20, 32'h02);
    exp_sta(m + 24, 32'h52);
    goto(m + 22);
    chk("mid_restart_port", 32'(port_sel_o), 32'd0);
    chk("mid_restart_busy", 32'(busy_o),     32'd1);
    goto(m + 23);
    chk("mid_enum_port", 32'(port_sel_o), 32'd5);
    chk("mid_enum_rstn", 32'(dev_rstn_o), 32'h10);
    goto(m + 30);
    dev_connected_i = 6'b010000;
    exp_sta(m + 32, 32'h51);
    goto(m + 31);
    chk("mid_active_busy", 32'(busy_o), 32'd0);
    watch3 = 1'b0;
    chk("mid_dev4_never_released", 32'(saw3), 32'd0);

    // Attach device 2 with its connected flag already up.
    a = m + 35;
    goto(a);
    req_sel_i       = 3'd2;
    dev_connected_i = 6'b000010;
    exp_sta(a + 2,  32'h02);
    exp_sta(a + 10, 32'h02);
    exp_sta(a + 14, 32'h22);
    exp_sta(a + 15, 32'h21);
    goto(a + 13);
    chk("dev2_enum_port", 32'(port_sel_o), 32'd2);
    chk("dev2_enum_busy", 32'(busy_o),     32'd1);
    goto(a + 14);
    chk("dev2_active_busy", 32'(busy_o), 32'd0);

    // Device 2 drops off and reconnects before the reloaded timeout.
    d = a + 20;
    goto(d);
    dev_connected_i = 6'b0;
    exp_sta(d + 2,  32'h22);
    exp_sta(d + 32, 32'h21);
    goto(d + 1);
    chk("disc_enum_busy", 32'(busy_o),     32'd1);
    chk("disc_enum_port", 32'(port_sel_o), 32'd2);
    chk("disc_enum_rstn", 32'(dev_rstn_o), 32'h02);
    goto(d + 29);
    chk("disc_still_enum", 32'(busy_o), 32'd1);
    goto(d + 30);
    dev_connected_i = 6'b000010;
    goto(d + 31);
    chk("disc_reactive_busy", 32'(busy_o),     32'd0);
    chk("disc_reactive_port", 32'(port_sel_o), 32'd2);

    // Park from ACTIVE.
    u = d + 35;
    goto(u);
    req_sel_i = 3'd0;
    exp_sta(u + 2,  32'h02);
    exp_sta(u + 10, 32'h00);
    goto(u + 8);
    chk("park_disc_busy", 32'(busy_o), 32'd1);
    goto(u + 9);
    chk("park_idle_busy", 32'(busy_o),     32'd0);
    chk("park_idle_port", 32'(port_sel_o), 32'd0);
    chk("park_idle_rstn", 32'(dev_rstn_o), 32'd0);

    // Reset in the middle of DISC.
    r = u + 15;
    goto(r);
    req_sel_i = 3'd6;
    exp_sta(r + 2, 32'h02);
    goto(r + 4);
    rstn_i    = 1'b0;
    req_sel_i = 3'd0;
    goto(r + 5);
    chk("mrst_port",     32'(port_sel_o), 32'd0);
    chk("mrst_rstn",     32'(dev_rstn_o), 32'd0);
    chk("mrst_busy",     32'(busy_o),     32'd0);
    chk("mrst_sta_we",   32'(sta_we_o),   32'd0);
    chk("mrst_sta_data", sta_data_o,      32'd0);
    rstn_i = 1'b1;
    goto(r + 20);
    chk("mrst_stays_idle", 32'(busy_o), 32'd0);

    chk("sta_all_seen", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_port_sequencer.md
# usb_port_sequencer

Controller that hands the single physical USB port (D+/D−/pull-up) from one emulated device core to another. It takes the device code written to the CCR register and sequences a disconnect, a device-core reset, and a connect-and-wait. It drives the port-mux select and per-device resets, and posts status into the STA register through the peripheral write port of the USB register file. It sits between the register file and the device cores (audio, camera, disk, keyboard, serial, serial2) inside the USB peripheral.

## Interface
- DISC_CYCLES, 480000: port parked (pull-up off, lines released) before a new device attaches; 10 ms at 48 MHz.
- RST_CYCLES, 16: device-core reset hold after disconnect.
- CONN_TIMEOUT, 48000000: maximum wait for the device's connected flag; 1 s.
- CNT_W, 26: timer width; must hold max(DISC_CYCLES, RST_CYCLES, CONN_TIMEOUT).
- clk_i  in  1  single clock, rising edge.
- rstn_i  in  1  synchronous, active-low reset.
- req_sel_i  in  3  requested device code (CCR[2:0]). 1..6 = device; 0 and 7 = park.
- dev_connected_i  in  6  connected flag per device, bit k-1 = device k.
- port_sel_o  out  3  mux select for port pins. 0 = parked bundle.
- dev_rstn_o  out  6  active-low reset per device core.
- busy_o  out  1  high while a switch is in progress.
- sta_we_o  out  1  one-cycle STA write strobe.
- sta_data_o  out  32  STA value: [0] connected, [1] busy, [2] timeout, [6:4] active device, other bits 0.

## Operation
- States: IDLE, DISC, RSTDEV, ENUM, ACTIVE, FAULT. Internal target register tgt holds the latched device code.
- Request detection: every cycle, compare req_sel_i against tgt. If they differ, latch tgt ← req_sel_i and enter DISC, from any state. This is also how a mid-sequence change restarts the sequence.
  - A code of 0 or 7 passes through DISC, then goes to IDLE instead of RSTDEV.
- DISC: port_sel_o=0; all dev_rstn_o=0. Lasts exactly DISC_CYCLES cycles. Then RSTDEV, or IDLE for a park code.
- RSTDEV: port_sel_o=0; all dev_rstn_o=0. Lasts exactly RST_CYCLES cycles. Then ENUM.
- ENUM: port_sel_o=tgt; dev_rstn_o[tgt-1]=1, all others 0. Timer loads CONN_TIMEOUT on entry.
  - dev_connected_i[tgt-1]=1 → ACTIVE.
  - Timer expires first → FAULT.
- ACTIVE: outputs as in ENUM. If dev_connected_i[tgt-1] falls, go to ENUM with the timer reloaded.
- FAULT: port_sel_o=0; target core held in reset. Stays until req_sel_i differs from tgt.
- IDLE: port_sel_o=0; all dev_rstn_o=0.
- busy_o=1 in DISC, RSTDEV and ENUM; 0 otherwise.
- STA posting: sta_we_o pulses for one cycle on the cycle after every state change.
  - sta_data_o holds the status of the new state.
  - [2] timeout is set only in FAULT.
  - [6:4] is tgt in ENUM/ACTIVE/FAULT, else 0.
- The timer is a down-counter. It loads N−1 on state entry and the state exits on the cycle the count reads 0. Unused high bits are zero.

## Timing
- Reset: state=IDLE, tgt=0, port_sel_o=0, dev_rstn_o=6'b0, busy_o=0, sta_we_o=0, sta_data_o=0, timer=0.
- A request first visible at edge n puts the block in DISC from edge n+1.
- ENUM is entered DISC_CYCLES+RST_CYCLES cycles after DISC entry. port_sel_o and dev_rstn_o change on the same edge as ENUM entry.
- ENUM→ACTIVE: one cycle after connected is sampled high.
- A new request and connected/timeout in the same cycle: the request wins (DISC).
- Reset asserted mid-sequence: back to the reset state on the next edge; no STA write.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package usb_pkg: device codes (RESET=0, AUDIO=1 … SERIAL2=6, RESET2=7), register offsets (CCR/RDR/TDR/STA = 0/4/8/12), state encoding, STA bit positions.
- Sub-module usb_dwell_timer: loadable down-counter with load, value and zero outputs, parameterised by CNT_W. Instantiated once and shared by all timed states.

## Test plan
Parameters: DISC_CYCLES=8, RST_CYCLES=4, CONN_TIMEOUT=32.
- Normal attach: reset, then req_sel_i=1 at cycle 0, dev_connected_i[0] raised at cycle 20.
  - DISC cycles 1–8, RSTDEV 9–12.
  - From cycle 13: port_sel_o=1 and dev_rstn_o=6'b000001.
  - ACTIVE at 21; sta_data_o=32'h11 with sta_we_o at 22.
- Timeout: req_sel_i=3, connected never asserted.
  - FAULT 32 cycles after ENUM entry; port_sel_o=0; STA = 32'h34.
  - Stays in FAULT while req_sel_i stays 3.
- Mid-sequence change: req_sel_i 4→5 during RSTDEV.
  - DISC restarts for a full 8 cycles.
  - ENUM then selects 5; dev_rstn_o[3] never goes high.
- Park: from ACTIVE on device 2, req_sel_i=0 → 8 DISC cycles → IDLE; STA=0; busy_o low.
- Disconnect: in ACTIVE, drop connected → ENUM with busy_o=1 and timer reloaded. Reassert within 32 cycles → ACTIVE again.
- Reset mid-DISC: rstn_i=0 for one cycle → all outputs at reset values on the next edge; no sta_we_o pulse.
